// File: rtl/uart_tx_framer_if.sv
// Parallel-side bundle of the UART transmit framer: the word and frame
// configuration flowing in, the serial line and busy flag flowing out.
interface uart_tx_framer_if #(
  parameter int Data_Width     = 8,
  parameter int Prescale_Width = 6
);
  logic [Data_Width-1:0]     P_Data;
  logic                      Data_Valid;
  logic                      Par_En;
  logic                      Par_Type;
  logic [Prescale_Width-1:0] Prescale;
  logic                      TX_Out;
  logic                      Busy;

  // Producer of words (drives data/config, observes line and busy)
  modport master (
    output P_Data, Data_Valid, Par_En, Par_Type, Prescale,
    input  TX_Out, Busy
  );

  // The framer itself
  modport slave (
    input  P_Data, Data_Valid, Par_En, Par_Type, Prescale,
    output TX_Out, Busy
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one captured word as
// start bit, data bits LSB first, optional parity bit, stop bit.
// Every bit is held for the captured prescale count of clk cycles.
module uart_tx_framer #(
  parameter int Data_Width     = 8,
  parameter int Prescale_Width = 6
) (
  input logic              clk,
  input logic              rst,
  uart_tx_framer_if.slave  bus
);

  localparam int BIT_W = (Data_Width > 1) ? $clog2(Data_Width) : 1;
  localparam logic [BIT_W-1:0]          LAST_BIT   = BIT_W'(Data_Width - 1);
  localparam logic [BIT_W-1:0]          BIT_ONE    = BIT_W'(32'd1);
  localparam logic [Prescale_Width-1:0] PRESC_ONE  = Prescale_Width'(32'd1);
  localparam logic [Prescale_Width-1:0] PRESC_ZERO = {Prescale_Width{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_f(input logic [Data_Width-1:0] d,
                                    input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                    state_q;
  logic [Data_Width-1:0]     data_q;      // shifts right as data bits go out
  logic                      par_en_q;
  logic                      par_bit_q;
  logic [Prescale_Width-1:0] presc_q;
  logic [Prescale_Width-1:0] edge_cnt_q;
  logic [BIT_W-1:0]          bit_cnt_q;
  logic                      tx_q;
  logic                      busy_q;

  logic [Prescale_Width-1:0] presc_d;
  logic                      bit_done;

  // Effective prescale for capture (0 behaves as 1) and end-of-bit strobe
  always_comb begin
    presc_d  = bus.Prescale;
    bit_done = 1'b0;
    if (bus.Prescale == PRESC_ZERO) begin
      presc_d = PRESC_ONE;
    end else begin
      presc_d = bus.Prescale;
    end
    if (edge_cnt_q == (presc_q - PRESC_ONE)) begin
      bit_done = 1'b1;
    end else begin
      bit_done = 1'b0;
    end
  end

  // Frame state machine; line and busy are registered here directly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= {Data_Width{1'b0}};
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      presc_q    <= PRESC_ONE;
      edge_cnt_q <= PRESC_ZERO;
      bit_cnt_q  <= {BIT_W{1'b0}};
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // Cycle counter within the current bit runs only during a frame
      if (busy_q) begin
        if (bit_done) begin
          edge_cnt_q <= PRESC_ZERO;
        end else begin
          edge_cnt_q <= edge_cnt_q + PRESC_ONE;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.Data_Valid) begin
            data_q     <= bus.P_Data;
            par_en_q   <= bus.Par_En;
            par_bit_q  <= parity_f(bus.P_Data, bus.Par_Type);
            presc_q    <= presc_d;
            edge_cnt_q <= PRESC_ZERO;
            bit_cnt_q  <= {BIT_W{1'b0}};
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end

        START: begin
          if (bit_done) begin
            tx_q    <= data_q[0];
            state_q <= DATA;
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_cnt_q == LAST_BIT) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
              tx_q      <= data_q[1];
              data_q    <= data_q >> 1;
            end
          end
        end

        PARITY: begin
          if (bit_done) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end

        STOP: begin
          if (bit_done) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.TX_Out = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: a table of frames with hand-derived
// line bit sequences and busy lengths, plus hand-written reset, held-valid
// and mid-frame-reset sequences. Outputs are sampled on the falling edge.
module tb_uart_tx_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_framer_if #(.Data_Width(8), .Prescale_Width(6)) bus ();

  uart_tx_framer #(.Data_Width(8), .Prescale_Width(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // One frame: stimulus plus expected line bits (index 0 sent first)
  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_type;
    logic [5:0]  prescale;
    logic [10:0] bits;
    int          len;      // expected Busy-high cycles
    logic        disturb;  // poke inputs mid-frame
    logic        hold;     // leave Data_Valid high at the end
  } frame_t;

  frame_t tbl [7];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b at time %0t", name, act, exp, $time);
    end
  endtask

  // Apply one frame and check every cycle of it plus the first idle cycle
  task automatic run_frame(input frame_t f, input int idx);
    int eff;
    eff = (f.prescale == 6'd0) ? 1 : int'(f.prescale);
    @(negedge clk);
    bus.P_Data     = f.data;
    bus.Par_En     = f.par_en;
    bus.Par_Type   = f.par_type;
    bus.Prescale   = f.prescale;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    if (!f.hold) bus.Data_Valid = 1'b0;
    for (int c = 0; c < f.len; c++) begin
      if (f.disturb && c == f.len / 2) begin
        bus.Data_Valid = 1'b1;
        bus.P_Data     = 8'h3C;
        bus.Prescale   = 6'd3;
        bus.Par_En     = ~f.par_en;
        bus.Par_Type   = ~f.par_type;
      end
      if (f.disturb && c == f.len / 2 + 1) bus.Data_Valid = 1'b0;
      chk($sformatf("frame%0d tx c%0d", idx, c), bus.TX_Out, f.bits[c / eff]);
      chk($sformatf("frame%0d busy c%0d", idx, c), bus.Busy, 1'b1);
      @(negedge clk);
    end
    chk($sformatf("frame%0d busy_end", idx), bus.Busy, 1'b0);
    chk($sformatf("frame%0d tx_end", idx), bus.TX_Out, 1'b1);
  endtask

  // Bounded wait for Busy to drop; expiry counts as a failure
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.Busy === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL %s: Busy still 1 after %0d cycles, expected 0", name, k);
    end
  endtask

  initial begin
    frame_t f_abort;
    frame_t f_after;

    // data, par_en, par_type, prescale, bits {stop, [par,] data, start}, len
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 6'd8, {1'b0, 1'b1, 8'hA5, 1'b0}, 80, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 6'd4, {1'b1, 1'b1, 8'h07, 1'b0}, 44, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 6'd4, {1'b1, 1'b0, 8'h07, 1'b0}, 44, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 6'd1, {1'b0, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b0, 6'd0, {1'b0, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 1'b0};
    tbl[5] = '{8'hA5, 1'b0, 1'b0, 6'd8, {1'b0, 1'b1, 8'hA5, 1'b0}, 80, 1'b1, 1'b0};
    tbl[6] = '{8'h3C, 1'b1, 1'b0, 6'd2, {1'b1, 1'b0, 8'h3C, 1'b0}, 22, 1'b0, 1'b0};

    bus.P_Data     = 8'h00;
    bus.Par_En     = 1'b0;
    bus.Par_Type   = 1'b0;
    bus.Prescale   = 6'd1;
    bus.Data_Valid = 1'b1;

    // Reset held 3 cycles with Data_Valid high: line idle, not busy
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst tx %0d", i), bus.TX_Out, 1'b1);
      chk($sformatf("rst busy %0d", i), bus.Busy, 1'b0);
    end
    rst = 1'b0;
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle tx %0d", i), bus.TX_Out, 1'b1);
      chk($sformatf("idle busy %0d", i), bus.Busy, 1'b0);
    end

    // Table of frames
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i], i);
    end

    // Held Data_Valid: next frame begins one cycle after Busy falls
    begin
      frame_t fh;
      fh = '{8'h55, 1'b0, 1'b0, 6'd1, {1'b0, 1'b1, 8'h55, 1'b0}, 10, 1'b0, 1'b1};
      run_frame(fh, 10);
      @(negedge clk);
      chk("held restart busy", bus.Busy, 1'b1);
      chk("held restart tx", bus.TX_Out, 1'b0);
      bus.Data_Valid = 1'b0;
      wait_idle("held drain");
      chk("held drain tx", bus.TX_Out, 1'b1);
    end

    // Reset during data bit 3 (frame bit 4, cycles 16..19 at prescale 4)
    f_abort = '{8'hA5, 1'b0, 1'b0, 6'd4, {1'b0, 1'b1, 8'hA5, 1'b0}, 40, 1'b0, 1'b0};
    @(negedge clk);
    bus.P_Data     = f_abort.data;
    bus.Par_En     = 1'b0;
    bus.Prescale   = 6'd4;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort pre tx bit3", bus.TX_Out, 1'b0);
    chk("abort pre busy", bus.Busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort tx", bus.TX_Out, 1'b1);
    chk("abort busy", bus.Busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort idle tx", bus.TX_Out, 1'b1);
    chk("abort idle busy", bus.Busy, 1'b0);

    f_after = '{8'h5A, 1'b0, 1'b0, 6'd4, {1'b0, 1'b1, 8'h5A, 1'b0}, 40, 1'b0, 1'b0};
    run_frame(f_after, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Serialises one parallel data word into a UART frame: start bit, data bits LSB first, optional parity bit, stop bit.
- The transmit counterpart to the system's UART receiver; drives the serial line that the far-end receiver samples.
- Each bit is held for Prescale cycles of clk, so TX and RX share one oversampled clock and one prescale setting.
- Buffers exactly one frame: data and configuration are captured when a word is accepted.

Parameters:
- Data_Width, 8, number of data bits per frame.
- Prescale_Width, 6, width of the Prescale input and of the internal cycles-per-bit counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- P_Data  input  Data_Width  word to transmit; sampled only on the accept cycle.
- Data_Valid  input  1  request to transmit P_Data; accepted only while Busy=0.
- Par_En  input  1  1 = parity bit inserted; sampled on accept.
- Par_Type  input  1  0 = even, 1 = odd; sampled on accept.
- Prescale  input  Prescale_Width  clk cycles per bit; sampled on accept; 0 is treated as 1.
- TX_Out  output  1  serial line, registered; idles high.
- Busy  output  1  registered; high from the cycle after accept to the end of the stop bit.

Behaviour:
- Reset (rst=1 at a clk edge):
  - TX_Out=1, Busy=0, state=IDLE.
  - All counters and capture registers are cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high on the next edge.
- State machine: IDLE, START, DATA, PARITY, STOP.
- Accept:
  - Occurs at an edge where state=IDLE and Data_Valid=1.
  - Captures P_Data, Par_En, Par_Type and the effective Prescale (0 becomes 1).
  - Computes parity from the captured data: even = XOR of the bits; odd = inverted XOR.
  - At that same edge: state→START, TX_Out←0, Busy←1, edge counter←0, bit counter←0.
- Bit timing:
  - The edge counter increments every cycle while Busy=1.
  - When the edge counter reaches Prescale−1, the bit ends: the counter wraps to 0 and the next bit is driven at that edge.
  - Every bit is exactly Prescale cycles wide.
- Transitions at end-of-bit:
  - START→DATA: TX_Out←data[0].
  - DATA: bit counter increments; TX_Out←data[bit counter+1] until bit Data_Width−1 has completed.
  - Then DATA→PARITY if the captured Par_En=1 (TX_Out←parity bit), otherwise DATA→STOP (TX_Out←1).
  - PARITY→STOP: TX_Out←1.
  - STOP→IDLE: TX_Out stays 1, Busy←0.
- Frame length in cycles:
  - Busy is high for (Data_Width+2)×Prescale cycles, or (Data_Width+3)×Prescale when parity is enabled.
- Back-to-back frames:
  - The earliest next accept is the edge after Busy falls.
  - The line is high for the stop period plus at least 1 cycle between frames.
- Data_Valid while Busy=1 is ignored: no queuing, no error flag.
- Changes on P_Data, Par_En, Par_Type or Prescale during a frame have no effect on that frame.
- Data_Valid is level-sensitive: if it is held high, a new frame starts each time the block returns to IDLE.
- No combinational path from any input to any output.

Test Plan:
- Reset and idle: hold rst for 3 cycles with Data_Valid=1 → TX_Out=1 and Busy=0 throughout, and for 5 cycles after release with Data_Valid=0.
- Basic frame, no parity: Prescale=8, Par_En=0, P_Data=0xA5, 1-cycle Data_Valid → TX_Out is 0 for 8 cycles, then 1,0,1,0,0,1,0,1 (8 cycles each), then 1 for 8 cycles; Busy high exactly 80 cycles.
- Parity frame: Prescale=4, Par_En=1, P_Data=0x07.
  - Par_Type=0 → parity bit=1; Par_Type=1 → parity bit=0.
  - Busy high 44 cycles in each case.
- Prescale edge cases: Prescale=1 with P_Data=0xFF → each bit lasts 1 cycle, frame 10 cycles; Prescale=0 → identical waveform to Prescale=1.
- Busy rejection and input stability:
  - Pulse Data_Valid with P_Data=0x3C mid-frame → ignored; the original frame completes unchanged.
  - Change Prescale mid-frame → no effect on bit width.
  - Held Data_Valid → the next frame starts exactly 1 cycle after Busy falls.
- Reset mid-frame: assert rst during data bit 3 → TX_Out=1 and Busy=0 after that edge; a new frame sent after release is correct from its start bit.
